// File: rtl/tinyqv_fetch_pkg.sv
// Shared definitions for the instruction prefetcher: FSM states, FIFO depth
// bounds and the flash strobe bundle.
package tinyqv_fetch_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 8;
    localparam int HW_W      = 16;
    localparam int HADDR_W   = 23;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_STOP   = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic start_read;
        logic stall_read;
        logic stop_read;
    } flash_ctl_t;

endpackage

// File: rtl/halfword_fifo.sv
// DEPTH x 16 halfword FIFO with flush; head is read straight from storage
// flops so a push is visible the cycle after it is accepted.
module halfword_fifo
    import tinyqv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push,
    input  logic [HW_W-1:0] din,
    input  logic            pop,
    input  logic            flush,
    output logic [HW_W-1:0] dout,
    output logic [CW-1:0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][HW_W-1:0] mem;
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic                       full, push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: drives sequential flash reads from a restart
// address and buffers returned halfwords, tagging the head with its address.
module instr_prefetch
    import tinyqv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               fetch_restart,
    input  logic [HADDR_W-1:0] fetch_addr,
    input  logic               fetch_stop,
    output logic [HW_W-1:0]    instr_data,
    output logic [HADDR_W-1:0] instr_addr,
    output logic               instr_valid,
    input  logic               instr_pop,
    output logic [HADDR_W:0]   flash_addr,
    output logic               flash_start_read,
    output logic               flash_stall_read,
    output logic               flash_stop_read,
    input  logic [HW_W-1:0]    flash_data,
    input  logic               flash_data_ready,
    input  logic               flash_busy
);

    localparam int FIFO_DEPTH = (DEPTH < DEPTH_MIN) ? DEPTH_MIN :
                                (DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t       state, state_nx;
    logic [HADDR_W-1:0] req_addr, req_nx, head_addr, head_nx;
    logic               pend, pend_nx;
    logic               flush, pop_ok, push, full, restart;
    logic [CW-1:0]      count;
    flash_ctl_t         fctl;

    assign instr_valid = (count != '0);
    assign pop_ok      = instr_pop && instr_valid;
    assign full        = (count == CW'(FIFO_DEPTH));
    assign restart     = fetch_restart && !fetch_stop;
    assign push        = (state == ST_STREAM) && flash_data_ready && !fctl.stall_read && !flush;

    always_comb begin
        state_nx        = state;
        req_nx          = req_addr;
        head_nx         = pop_ok ? head_addr + HADDR_W'(1) : head_addr;
        pend_nx         = pend;
        flush           = 1'b0;
        fctl            = '0;
        fctl.stall_read = full && !pop_ok;
        case (state)
            ST_IDLE: begin
                if (restart) begin
                    req_nx   = fetch_addr;
                    head_nx  = fetch_addr;
                    flush    = 1'b1;
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                fctl.start_read = !flash_busy;
                if (fetch_stop) begin
                    flush    = 1'b1;
                    pend_nx  = 1'b0;
                    state_nx = ST_STOP;
                end else if (restart) begin
                    req_nx  = fetch_addr;
                    head_nx = fetch_addr;
                    flush   = 1'b1;
                    // Start already on the wire with the old address: cancel it.
                    if (!flash_busy) begin
                        pend_nx  = 1'b1;
                        state_nx = ST_STOP;
                    end
                end else if (!flash_busy) begin
                    state_nx = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (fetch_stop) begin
                    flush    = 1'b1;
                    pend_nx  = 1'b0;
                    state_nx = ST_STOP;
                end else if (restart) begin
                    req_nx   = fetch_addr;
                    head_nx  = fetch_addr;
                    flush    = 1'b1;
                    pend_nx  = 1'b1;
                    state_nx = ST_STOP;
                end
            end
            ST_STOP: begin
                fctl.stop_read = 1'b1;
                if (fetch_stop) begin
                    pend_nx = 1'b0;
                end else if (restart) begin
                    req_nx  = fetch_addr;
                    head_nx = fetch_addr;
                    flush   = 1'b1;
                    pend_nx = 1'b1;
                end else if (!flash_busy) begin
                    state_nx = pend ? ST_START : ST_IDLE;
                    pend_nx  = 1'b0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            head_addr <= '0;
            pend      <= 1'b0;
        end else begin
            state     <= state_nx;
            req_addr  <= req_nx;
            head_addr <= head_nx;
            pend      <= pend_nx;
        end
    end

    halfword_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (flash_data),
        .pop   (instr_pop),
        .flush (flush),
        .dout  (instr_data),
        .count (count)
    );

    assign instr_addr       = head_addr;
    assign flash_addr       = {req_addr, 1'b0};
    assign flash_start_read = fctl.start_read;
    assign flash_stall_read = fctl.stall_read;
    assign flash_stop_read  = fctl.stop_read;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed scenario bench for instr_prefetch; the flash controller is played
// by hand-driven busy/ready/data vectors.
module tb_instr_prefetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fetch_restart, fetch_stop, instr_pop;
    logic [22:0] fetch_addr;
    logic [15:0] instr_data, flash_data;
    logic [22:0] instr_addr;
    logic        instr_valid;
    logic [23:0] flash_addr;
    logic        flash_start_read, flash_stall_read, flash_stop_read;
    logic        flash_data_ready, flash_busy;

    int vectors = 0;
    int miscompares = 0;

    instr_prefetch #(.DEPTH(4)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .fetch_restart    (fetch_restart),
        .fetch_addr       (fetch_addr),
        .fetch_stop       (fetch_stop),
        .instr_data       (instr_data),
        .instr_addr       (instr_addr),
        .instr_valid      (instr_valid),
        .instr_pop        (instr_pop),
        .flash_addr       (flash_addr),
        .flash_start_read (flash_start_read),
        .flash_stall_read (flash_stall_read),
        .flash_stop_read  (flash_stop_read),
        .flash_data       (flash_data),
        .flash_data_ready (flash_data_ready),
        .flash_busy       (flash_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input logic [22:0] a);
        fetch_restart = 1'b1; fetch_addr = a; flash_busy = 1'b0; flash_data_ready = 1'b0;
        tick;
        fetch_restart = 1'b0;
        tick;
        flash_busy = 1'b1;
    endtask

    task automatic stop_to_idle;
        fetch_stop = 1'b1; flash_busy = 1'b0; flash_data_ready = 1'b0; instr_pop = 1'b0;
        tick;
        fetch_stop = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        fetch_restart = 1'b0; fetch_stop = 1'b0; instr_pop = 1'b0; fetch_addr = '0;
        flash_data = '0; flash_data_ready = 1'b0; flash_busy = 1'b0;
        tick; tick;
        vectors++;
        if ({instr_valid, instr_data, instr_addr, flash_addr} !== 63'd0) begin
            miscompares++; $display("FAIL reset_outputs: got %h want 0", {instr_valid, instr_data, instr_addr, flash_addr});
        end
        vectors++;
        if ({flash_start_read, flash_stall_read, flash_stop_read} !== 3'b000) begin
            miscompares++; $display("FAIL reset_strobes: got %b want 000", {flash_start_read, flash_stall_read, flash_stop_read});
        end
        rstn = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        fetch_restart = 1'b1; fetch_addr = 23'h000100; flash_busy = 1'b0;
        #1;
        vectors++;
        if (flash_start_read !== 1'b0) begin
            miscompares++; $display("FAIL idle_no_start: got %b want 0", flash_start_read);
        end
        tick;
        fetch_restart = 1'b0;
        #1;
        vectors++;
        if ({flash_start_read, flash_addr} !== {1'b1, 24'h000200}) begin
            miscompares++; $display("FAIL basic_start: got %b/%h want 1/000200", flash_start_read, flash_addr);
        end
        tick;
        flash_busy = 1'b1; flash_data = 16'h1111; flash_data_ready = 1'b1;
        #1;
        vectors++;
        if ({flash_start_read, flash_stall_read} !== 2'b00) begin
            miscompares++; $display("FAIL stream_strobes: got %b want 00", {flash_start_read, flash_stall_read});
        end
        tick;
        flash_data = 16'h2222;
        vectors++;
        if ({instr_valid, instr_data, instr_addr} !== {1'b1, 16'h1111, 23'h000100}) begin
            miscompares++; $display("FAIL basic_first: got %b/%h/%h want 1/1111/000100", instr_valid, instr_data, instr_addr);
        end
        tick;
        flash_data_ready = 1'b0; instr_pop = 1'b1;
        tick;
        instr_pop = 1'b0;
        vectors++;
        if ({instr_valid, instr_data, instr_addr} !== {1'b1, 16'h2222, 23'h000101}) begin
            miscompares++; $display("FAIL basic_second: got %b/%h/%h want 1/2222/000101", instr_valid, instr_data, instr_addr);
        end
        instr_pop = 1'b1;
        tick;
        instr_pop = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_drained: got %b want 0", instr_valid);
        end
        stop_to_idle;
    endtask

    task automatic test_stall;
        start_stream(23'h000200);
        for (int i = 0; i < 4; i++) begin
            flash_data = 16'hA000 + 16'(i); flash_data_ready = 1'b1;
            #1;
            vectors++;
            if (flash_stall_read !== 1'b0) begin
                miscompares++; $display("FAIL stall_early[%0d]: got %b want 0", i, flash_stall_read);
            end
            tick;
        end
        flash_data = 16'hA004;
        tick;
        vectors++;
        if ({flash_stall_read, instr_data} !== {1'b1, 16'hA000}) begin
            miscompares++; $display("FAIL stall_full: got %b/%h want 1/a000", flash_stall_read, instr_data);
        end
        instr_pop = 1'b1;
        #1;
        vectors++;
        if (flash_stall_read !== 1'b0) begin
            miscompares++; $display("FAIL stall_drop_on_pop: got %b want 0", flash_stall_read);
        end
        tick;
        instr_pop = 1'b0; flash_data_ready = 1'b0;
        #1;
        vectors++;
        if (flash_stall_read !== 1'b1) begin
            miscompares++; $display("FAIL stall_full_again: got %b want 1", flash_stall_read);
        end
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if ({instr_valid, instr_data, instr_addr} !== {1'b1, 16'hA000 + 16'(i), 23'h000200 + 23'(i)}) begin
                miscompares++; $display("FAIL stall_drain[%0d]: got %b/%h/%h want 1/%h/%h", i, instr_valid, instr_data, instr_addr, 16'hA000 + 16'(i), 23'h000200 + 23'(i));
            end
            instr_pop = 1'b1;
            tick;
        end
        instr_pop = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL stall_empty: got %b want 0", instr_valid);
        end
        stop_to_idle;
    endtask

    task automatic test_restart_midstream;
        start_stream(23'h000300);
        for (int i = 0; i < 3; i++) begin
            flash_data = 16'hB000 + 16'(i); flash_data_ready = 1'b1;
            tick;
        end
        fetch_restart = 1'b1; fetch_addr = 23'h000400; flash_data = 16'hBAD0;
        tick;
        fetch_restart = 1'b0; flash_data = 16'hDEAD;
        vectors++;
        if ({instr_valid, flash_stop_read, flash_start_read, flash_addr} !== {3'b010, 24'h000800}) begin
            miscompares++; $display("FAIL restart_flush: got %b%b%b/%h want 010/000800", instr_valid, flash_stop_read, flash_start_read, flash_addr);
        end
        for (int i = 0; i < 2; i++) begin
            tick;
            vectors++;
            if ({instr_valid, flash_stop_read} !== 2'b01) begin
                miscompares++; $display("FAIL restart_hold_stop[%0d]: got %b want 01", i, {instr_valid, flash_stop_read});
            end
        end
        flash_busy = 1'b0;
        tick;
        flash_data_ready = 1'b0;
        vectors++;
        if ({flash_start_read, flash_stop_read, instr_valid, flash_addr} !== {3'b100, 24'h000800}) begin
            miscompares++; $display("FAIL restart_start: got %b%b%b/%h want 100/000800", flash_start_read, flash_stop_read, instr_valid, flash_addr);
        end
        tick;
        flash_busy = 1'b1; flash_data = 16'hC000; flash_data_ready = 1'b1;
        tick;
        flash_data_ready = 1'b0;
        vectors++;
        if ({instr_valid, instr_data, instr_addr} !== {1'b1, 16'hC000, 23'h000400}) begin
            miscompares++; $display("FAIL restart_new_data: got %b/%h/%h want 1/c000/000400", instr_valid, instr_data, instr_addr);
        end
        stop_to_idle;
    endtask

    task automatic test_restart_in_start;
        fetch_restart = 1'b1; fetch_addr = 23'h000600; flash_busy = 1'b1;
        tick;
        fetch_addr = 23'h000700;
        tick;
        fetch_restart = 1'b0;
        vectors++;
        if ({flash_start_read, flash_stop_read, flash_addr} !== {2'b00, 24'h000E00}) begin
            miscompares++; $display("FAIL start_readdr: got %b%b/%h want 00/000e00", flash_start_read, flash_stop_read, flash_addr);
        end
        flash_busy = 1'b0;
        #1;
        vectors++;
        if (flash_start_read !== 1'b1) begin
            miscompares++; $display("FAIL start_issue: got %b want 1", flash_start_read);
        end
        tick;
        flash_busy = 1'b1; flash_data = 16'hE000; flash_data_ready = 1'b1;
        tick;
        flash_data_ready = 1'b0;
        vectors++;
        if ({instr_valid, instr_data, instr_addr} !== {1'b1, 16'hE000, 23'h000700}) begin
            miscompares++; $display("FAIL start_data: got %b/%h/%h want 1/e000/000700", instr_valid, instr_data, instr_addr);
        end
        stop_to_idle;
    endtask

    task automatic test_pop_empty;
        start_stream(23'h000050);
        instr_pop = 1'b1;
        tick; tick;
        instr_pop = 1'b0; flash_data = 16'h5A5A; flash_data_ready = 1'b1;
        tick;
        flash_data_ready = 1'b0;
        vectors++;
        if ({instr_valid, instr_data, instr_addr} !== {1'b1, 16'h5A5A, 23'h000050}) begin
            miscompares++; $display("FAIL pop_empty: got %b/%h/%h want 1/5a5a/000050", instr_valid, instr_data, instr_addr);
        end
        stop_to_idle;
    endtask

    task automatic test_wrap;
        start_stream(23'h7FFFFF);
        vectors++;
        if (flash_addr !== 24'hFFFFFE) begin
            miscompares++; $display("FAIL wrap_flash_addr: got %h want fffffe", flash_addr);
        end
        flash_data = 16'hD000; flash_data_ready = 1'b1;
        tick;
        flash_data = 16'hD001;
        tick;
        flash_data_ready = 1'b0;
        vectors++;
        if (instr_addr !== 23'h7FFFFF) begin
            miscompares++; $display("FAIL wrap_head: got %h want 7fffff", instr_addr);
        end
        instr_pop = 1'b1;
        tick;
        instr_pop = 1'b0;
        vectors++;
        if ({instr_valid, instr_data, instr_addr} !== {1'b1, 16'hD001, 23'h000000}) begin
            miscompares++; $display("FAIL wrap_pop: got %b/%h/%h want 1/d001/000000", instr_valid, instr_data, instr_addr);
        end
        stop_to_idle;
    endtask

    task automatic test_restart_stop_same;
        start_stream(23'h000080);
        fetch_restart = 1'b1; fetch_stop = 1'b1; fetch_addr = 23'h000500;
        tick;
        fetch_restart = 1'b0; fetch_stop = 1'b0;
        vectors++;
        if ({flash_stop_read, flash_addr} !== {1'b1, 24'h000100}) begin
            miscompares++; $display("FAIL both_stop: got %b/%h want 1/000100", flash_stop_read, flash_addr);
        end
        flash_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if ({flash_start_read, flash_stop_read} !== 2'b00) begin
                miscompares++; $display("FAIL both_idle[%0d]: got %b want 00", i, {flash_start_read, flash_stop_read});
            end
        end
    endtask

    task automatic test_reset_mid;
        start_stream(23'h000010);
        flash_data = 16'hF000; flash_data_ready = 1'b1;
        tick;
        flash_data = 16'hF001;
        tick;
        flash_data_ready = 1'b0;
        rstn = 1'b0;
        #1;
        vectors++;
        if ({instr_valid, instr_data, instr_addr, flash_addr} !== 63'd0) begin
            miscompares++; $display("FAIL midreset_outputs: got %h want 0", {instr_valid, instr_data, instr_addr, flash_addr});
        end
        vectors++;
        if ({flash_start_read, flash_stall_read, flash_stop_read} !== 3'b000) begin
            miscompares++; $display("FAIL midreset_strobes: got %b want 000", {flash_start_read, flash_stall_read, flash_stop_read});
        end
        flash_busy = 1'b0;
        tick;
        rstn = 1'b1;
        tick;
        vectors++;
        if ({flash_start_read, flash_stop_read, instr_valid} !== 3'b000) begin
            miscompares++; $display("FAIL midreset_idle: got %b want 000", {flash_start_read, flash_stop_read, instr_valid});
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_restart_midstream;
        test_restart_in_start;
        test_pop_empty;
        test_wrap;
        test_restart_stop_same;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
